call_scheduler: RTL and testbench

- Sits in front of the three-floor freight-lift `fsm` and drives its `button[2:0]` input.
- Latches floor calls from the call panel and picks the next target with a direction-preserving (SCAN) policy.
- Issues a single-cycle request pulse to `fsm`, tracks the lift through motion to arrival, then holds a dwell (loading) time.
- Shares `clk`/`rst` with `fsm`, so both come out of reset at floor 1.

---
 rtl/lift_pkg.sv | 27 ++
 rtl/dwell_timer.sv | 33 +++
 rtl/call_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_call_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared definitions for the freight-lift controller and its call scheduler:
// floor indices, motor codes, scheduler states.
package lift_pkg;

    localparam logic [1:0] P1 = 2'd0;
    localparam logic [1:0] P2 = 2'd1;
    localparam logic [1:0] P3 = 2'd2;

    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DN   = 2'b10;

    localparam logic [3:0] DISP_OFF = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_MOVE,
        MOVING,
        DWELL
    } sched_state_t;

    function automatic logic [2:0] onehot3(input logic [1:0] f);
        return 3'b001 << f;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loading-time counter: load arms a DWELL_CYCLES-long window, done is high
// once the window has elapsed. Counts down and sticks at zero.
module dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    if (DWELL_CYCLES < 1 || ((DWELL_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("dwell_timer: CNT_W=%0d cannot hold DWELL_CYCLES-1=%0d", CNT_W, DWELL_CYCLES - 1);
    end

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (en && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/call_scheduler.sv
// Floor-call scheduler in front of the lift fsm: latches calls, picks the next
// floor with a SCAN policy, pulses the fsm button and follows the car to arrival.
module call_scheduler
    import lift_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26,
    parameter int START_TMO    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] call_btn,
    input  logic [2:0] endstop,
    input  logic [1:0] motor,
    output logic [2:0] req,
    output logic [2:0] pending,
    output logic [1:0] cur_floor,
    output logic       busy
);

    if (START_TMO < 1) begin : g_bad_tmo
        $error("call_scheduler: START_TMO must be at least 1");
    end

    localparam int TMO_W = $clog2(START_TMO + 1);

    sched_state_t     state;
    logic [2:0]       btn_q;
    logic [2:0]       rise;
    logic [2:0]       clr;
    logic [1:0]       target;
    logic             dir;        // 1 = up
    logic [TMO_W-1:0] tmo;

    logic             up_ok, dn_ok;
    logic [1:0]       up_floor, dn_floor;
    logic [1:0]       sel_floor;
    logic             sel_dir;
    logic             arrive;
    logic             dw_load;
    logic             dw_done;

    assign rise   = call_btn & ~btn_q;
    assign arrive = (motor == STOP) && endstop[target];
    assign busy   = (state != IDLE);

    // Nearest pending floor on each side of the car; keep heading while
    // there is work ahead, otherwise turn around.
    always_comb begin
        up_ok    = 1'b0;
        up_floor = cur_floor;
        dn_ok    = 1'b0;
        dn_floor = cur_floor;
        case (cur_floor)
            P1: begin
                if (pending[P2]) begin
                    up_ok    = 1'b1;
                    up_floor = P2;
                end else if (pending[P3]) begin
                    up_ok    = 1'b1;
                    up_floor = P3;
                end
            end
            P2: begin
                if (pending[P3]) begin
                    up_ok    = 1'b1;
                    up_floor = P3;
                end
                if (pending[P1]) begin
                    dn_ok    = 1'b1;
                    dn_floor = P1;
                end
            end
            default: begin
                if (pending[P2]) begin
                    dn_ok    = 1'b1;
                    dn_floor = P2;
                end else if (pending[P1]) begin
                    dn_ok    = 1'b1;
                    dn_floor = P1;
                end
            end
        endcase
        if (dir ? up_ok : !dn_ok) begin
            sel_floor = up_floor;
            sel_dir   = 1'b1;
        end else begin
            sel_floor = dn_floor;
            sel_dir   = 1'b0;
        end
    end

    // Calls that get served this cycle; the clear beats a same-cycle set.
    always_comb begin
        clr     = '0;
        dw_load = 1'b0;
        case (state)
            IDLE, DWELL: begin
                if (pending[cur_floor]) begin
                    clr     = onehot3(cur_floor);
                    dw_load = 1'b1;
                end
            end
            MOVING: begin
                if (arrive) begin
                    clr     = onehot3(target);
                    dw_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .CNT_W       (CNT_W)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .load(dw_load),
        .en  (state == DWELL),
        .done(dw_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            pending   <= '0;
            btn_q     <= '0;
            cur_floor <= P1;
            target    <= P1;
            dir       <= 1'b1;
            tmo       <= '0;
        end else begin
            req     <= '0;
            btn_q   <= call_btn;
            pending <= (pending | rise) & ~clr;
            case (state)
                IDLE: begin
                    if (pending[cur_floor]) begin
                        state <= DWELL;
                    end else if (pending != '0) begin
                        target <= sel_floor;
                        dir    <= sel_dir;
                        req    <= onehot3(sel_floor);
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo   <= '0;
                    state <= WAIT_MOVE;
                end
                WAIT_MOVE: begin
                    if (motor != STOP)
                        state <= MOVING;
                    else if (tmo == TMO_W'(START_TMO - 1))
                        state <= IDLE;   // call stays pending and is retried
                    else
                        tmo <= tmo + TMO_W'(1);
                end
                MOVING: begin
                    if (arrive) begin
                        cur_floor <= target;
                        if (target == P1)
                            dir <= 1'b1;
                        else if (target == P3)
                            dir <= 1'b0;
                        else
                            dir <= (target > cur_floor);
                        state <= DWELL;
                    end
                end
                DWELL: begin
                    if (!pending[cur_floor] && dw_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_req_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req));
    a_req_issue:  assert property (@(posedge clk) disable iff (rst) (req != '0) |-> (state == ISSUE));

endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: a scripted table, directed corner sequences and a
// random run, all against a floor-level reference model plus a simple lift model.
module tb_call_scheduler;
    import lift_pkg::*;

    localparam int DW     = 10;
    localparam int CW     = 4;
    localparam int TMO    = 8;
    localparam int TRAVEL = 3;

    localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_MOVE = 3, M_DWELL = 4;
    localparam int W_FLOOR = 0, W_REQ = 1, W_BUSY = 2, W_MOTOR = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] call_btn, endstop, req, pending;
    logic [1:0] motor, cur_floor;
    logic       busy;

    always #5 clk = ~clk;

    call_scheduler #(
        .DWELL_CYCLES(DW),
        .CNT_W       (CW),
        .START_TMO   (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .call_btn (call_btn),
        .endstop  (endstop),
        .motor    (motor),
        .req      (req),
        .pending  (pending),
        .cur_floor(cur_floor),
        .busy     (busy)
    );

    int nvec = 0;
    int nerr = 0;

    // reference model: floors as integers, direction as +1/-1
    int         m_mode, m_floor, m_dir, m_tgt, m_wait, m_left;
    logic [2:0] m_pend, m_prev;

    // lift model standing in for the fsm
    int l_pos, l_dest, l_cd, l_trav;
    bit l_dead;

    typedef struct {
        logic [2:0] btn;
        int         reps;
        logic [2:0] req;
        logic [2:0] pend;
        int         cur;
        bit         busy;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(logic [2:0] p, int from, int d);
        for (int f = from + d; f >= 0 && f <= 2; f += d)
            if (p[f]) return f;
        return -1;
    endfunction

    task automatic model_update();
        logic [2:0] rise, clr;
        int t;
        if (rst) begin
            m_mode = M_IDLE; m_floor = 0; m_dir = 1; m_tgt = 0;
            m_wait = 0; m_left = 0; m_pend = 0; m_prev = 0;
            return;
        end
        rise   = call_btn & ~m_prev;
        m_prev = call_btn;
        clr    = 0;
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    clr[m_floor] = 1'b1; m_mode = M_DWELL; m_left = DW;
                end else if (m_pend != 0) begin
                    t = pick(m_pend, m_floor, m_dir);
                    if (t < 0) begin
                        m_dir = -m_dir;
                        t = pick(m_pend, m_floor, m_dir);
                    end
                    m_tgt = t; m_mode = M_ISSUE;
                end
            end
            M_ISSUE: begin m_mode = M_WAIT; m_wait = 0; end
            M_WAIT: begin
                if (motor != STOP) m_mode = M_MOVE;
                else begin
                    m_wait++;
                    if (m_wait == TMO) m_mode = M_IDLE;
                end
            end
            M_MOVE: begin
                if (motor == STOP && endstop[m_tgt]) begin
                    m_dir = (m_tgt > m_floor) ? 1 : -1;
                    if (m_tgt == 0) m_dir = 1;
                    if (m_tgt == 2) m_dir = -1;
                    m_floor = m_tgt; clr[m_tgt] = 1'b1; m_mode = M_DWELL; m_left = DW;
                end
            end
            default: begin
                if (m_pend[m_floor]) begin
                    clr[m_floor] = 1'b1; m_left = DW;
                end else if (m_left == 1) m_mode = M_IDLE;
                else m_left--;
            end
        endcase
        m_pend = (m_pend | rise) & ~clr;
    endtask

    // Two cycles from request to motion, TRAVEL cycles per floor, P2 endstop
    // flashes while passing it on a P1<->P3 trip.
    task automatic lift_update();
        int d;
        if (l_cd > 0) begin
            l_cd--;
            if (l_cd == 0) begin
                d = l_dest - l_pos;
                motor = (d > 0) ? UP : DN;
                endstop = 0;
                l_trav = TRAVEL * ((d < 0) ? -d : d);
            end
        end else if (l_trav > 0) begin
            l_trav--;
            if (l_trav == 0) begin
                motor = STOP; l_pos = l_dest; endstop = 3'(1 << l_pos);
            end else if (l_trav == TRAVEL && l_dest + l_pos == 2 && l_dest != l_pos)
                endstop = 3'b010;
            else
                endstop = 0;
        end else if (req != 0 && !l_dead) begin
            l_dest = (req == 3'b001) ? 0 : (req == 3'b010) ? 1 : 2;
            l_cd = 2;
        end
    endtask

    task automatic step(bit mchk);
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (mchk) begin
            chk("req", int'(req), (m_mode == M_ISSUE) ? (1 << m_tgt) : 0);
            chk("pending", int'(pending), int'(m_pend));
            chk("cur_floor", int'(cur_floor), m_floor);
            chk("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
        end
        lift_update();
    endtask

    task automatic do_reset();
        rst = 1'b1; call_btn = 0;
        l_pos = 0; l_cd = 0; l_trav = 0; motor = STOP; endstop = 3'b001;
        step(0);
        step(0);
        rst = 1'b0;
    endtask

    task automatic press(logic [2:0] b);
        call_btn = b;
        step(1);
        call_btn = 0;
    endtask

    task automatic run_until(int what, int val, int budget, string name, output int n);
        bit ok;
        ok = 0;
        n = 0;
        while (!ok && n < budget) begin
            step(1);
            n++;
            case (what)
                W_FLOOR: ok = (int'(cur_floor) == val);
                W_REQ:   ok = (req != 0);
                W_BUSY:  ok = (int'(busy) == val);
                default: ok = (motor != STOP);
            endcase
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: event not seen within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{3'b100, 1,  3'b000, 3'b100, 0, 1'b0};
        tbl[1] = '{3'b100, 1,  3'b100, 3'b100, 0, 1'b1};
        tbl[2] = '{3'b000, 8,  3'b000, 3'b100, 0, 1'b1};
        tbl[3] = '{3'b000, DW, 3'b000, 3'b000, 2, 1'b1};
        tbl[4] = '{3'b000, 1,  3'b000, 3'b000, 2, 1'b0};

        call_btn = 0; motor = STOP; endstop = 3'b001; l_dead = 0; l_dest = 0; rst = 1'b1;
        do_reset();
        chk("rst_req", int'(req), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_cur_floor", int'(cur_floor), 0);
        chk("rst_busy", int'(busy), 0);

        // P3 call from floor 0: pending, request, travel, dwell, idle
        for (int i = 0; i < 5; i++)
            for (int r = 0; r < tbl[i].reps; r++) begin
                call_btn = tbl[i].btn;
                step(0);
                chk($sformatf("tbl%0d_req", i), int'(req), int'(tbl[i].req));
                chk($sformatf("tbl%0d_pending", i), int'(pending), int'(tbl[i].pend));
                chk($sformatf("tbl%0d_cur_floor", i), int'(cur_floor), tbl[i].cur);
                chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
            end

        // P3 then P2 while moving up: P3 first, P2 on the way back
        do_reset();
        press(3'b100);
        run_until(W_REQ, 0, 10, "s2_req1", n);
        chk("s2_req1_val", int'(req), 3'b100);
        run_until(W_MOTOR, 0, 10, "s2_move", n);
        press(3'b010);
        run_until(W_FLOOR, 2, 60, "s2_arrive_p3", n);
        chk("s2_p2_still_pending", int'(pending), 3'b010);
        run_until(W_REQ, 0, 40, "s2_req2", n);
        chk("s2_req2_val", int'(req), 3'b010);
        run_until(W_FLOOR, 1, 40, "s2_arrive_p2", n);
        chk("s2_pending_empty", int'(pending), 0);

        // At floor 1 heading up, P1+P3 together: P3 first, then P1
        do_reset();
        press(3'b010);
        run_until(W_FLOOR, 1, 40, "s3_arrive_p2", n);
        run_until(W_BUSY, 0, 30, "s3_idle", n);
        press(3'b101);
        run_until(W_REQ, 0, 10, "s3_req1", n);
        chk("s3_req1_val", int'(req), 3'b100);
        run_until(W_FLOOR, 2, 40, "s3_arrive_p3", n);
        run_until(W_REQ, 0, 40, "s3_req2", n);
        chk("s3_req2_val", int'(req), 3'b001);
        run_until(W_FLOOR, 0, 60, "s3_arrive_p1", n);

        // Call for the current floor in IDLE and again in DWELL
        run_until(W_BUSY, 0, 30, "s4_idle", n);
        press(3'b001);
        chk("s4_idle_set", int'(pending), 3'b001);
        step(1);
        chk("s4_idle_clr", int'(pending), 0);
        chk("s4_idle_dwell", int'(busy), 1);
        chk("s4_idle_noreq", int'(req), 0);
        step(1); step(1); step(1);
        press(3'b001);
        chk("s4_dwell_set", int'(pending), 3'b001);
        step(1);
        chk("s4_dwell_clr", int'(pending), 0);
        run_until(W_BUSY, 0, 30, "s4_dwell_end", n);
        chk("s4_dwell_restart_len", n, DW);

        // Motor never starts: timeout, same request reissued, call kept
        do_reset();
        l_dead = 1;
        press(3'b010);
        run_until(W_REQ, 0, 10, "s5_req1", n);
        chk("s5_req1_val", int'(req), 3'b010);
        run_until(W_REQ, 0, 30, "s5_req2", n);
        chk("s5_retry_gap", n, TMO + 2);
        chk("s5_req2_val", int'(req), 3'b010);
        chk("s5_pending_kept", int'(pending), 3'b010);
        l_dead = 0;
        run_until(W_FLOOR, 1, 60, "s5_arrive", n);

        // Reset while moving with P1+P2 pending
        do_reset();
        press(3'b100);
        run_until(W_FLOOR, 2, 60, "s6_arrive_p3", n);
        run_until(W_BUSY, 0, 30, "s6_idle", n);
        press(3'b011);
        run_until(W_MOTOR, 0, 15, "s6_move", n);
        step(1);
        chk("s6_pending_moving", int'(pending), 3'b011);
        rst = 1'b1;
        l_pos = 0; l_cd = 0; l_trav = 0; motor = STOP; endstop = 3'b001;
        step(0);
        chk("s6_rst_pending", int'(pending), 0);
        chk("s6_rst_cur_floor", int'(cur_floor), 0);
        chk("s6_rst_req", int'(req), 0);
        chk("s6_rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Random calls, occasional dead motor and reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            if ($urandom_range(0, 299) == 0) l_dead = !l_dead;
            if ($urandom_range(0, 5) == 0) call_btn = 3'($urandom_range(0, 7));
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
